// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty flag and optional occupancy/almost-empty generator for the dual-clock FIFO.
// Optional level logic is enabled by defining RPTR_EMPTY_LEVEL_EN.
module rptr_empty_lvl #(
  parameter int unsigned ADDRSIZE      = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int unsigned PW = ADDRSIZE + 1;

  if (ADDRSIZE < 2 || AEMPTY_THRESH >= (1 << ADDRSIZE)) begin : g_param_check
    $error("rptr_empty_lvl: illegal ADDRSIZE/AEMPTY_THRESH");
  end

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] rlevel_next;
  logic          rempty_next;
  logic          raempty_next;

  // Next pointer and empty compare; a read while empty does not advance.
  always_comb begin
    rbinnext    = rbin + PW'(rinc & ~rempty);
    rgraynext   = (rbinnext >> 1) ^ rbinnext;
    rempty_next = (rgraynext == rq2_wptr);
  end

`ifdef RPTR_EMPTY_LEVEL_EN
  localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wbin_s;

  // Gray-to-binary of the synchronized write pointer, then modular distance.
  always_comb begin
    wbin_s = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
    rlevel_next  = wbin_s - rbinnext;
    raempty_next = (rlevel_next <= THRESH);
  end
`else
  always_comb begin
    rlevel_next  = '0;
    raempty_next = rempty_next;
  end
`endif

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      rlevel     <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin    <= rbinnext;
      rptr    <= rgraynext;
      rempty  <= rempty_next;
      raempty <= raempty_next;
      rlevel  <= rlevel_next;
      if (rinc && rempty) begin
        runderflow <= 1'b1;
      end
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: doc/rptr_empty_lvl.md
# rptr_empty_lvl

Read-side pointer and empty-flag generator for the dual-clock FIFO. It is the read-domain counterpart of the write-pointer/full block. It keeps the binary read address and the Gray-coded read pointer that is exported to the write domain. It compares its next Gray pointer against the write pointer, already synchronized into the read domain, to produce a registered `rempty`; it can optionally also produce an occupancy level and an almost-empty flag.

## Interface
Parameters:
- `ADDRSIZE`, default 4: FIFO depth is 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits wide; legal values are ≥ 2.
- `AEMPTY_THRESH`, default 2: almost-empty threshold in words. Legal range is 0 .. 2^ADDRSIZE-1.

Ports:
- `rclk`, input, 1: read-domain clock. This is the only clock.
- `rrst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `rclk`.
- `rinc`, input, 1: read request. It is honoured only when `rempty`=0.
- `rq2_wptr`, input, ADDRSIZE+1: Gray-coded write pointer, already double-synchronized into `rclk`.
- `raddr`, output, ADDRSIZE: RAM read address, equal to `rbin[ADDRSIZE-1:0]`.
- `rptr`, output, ADDRSIZE+1: registered Gray read pointer, sent to the write-domain synchronizer.
- `rempty`, output, 1: registered empty flag.
- `raempty`, output, 1: registered almost-empty flag.
- `rlevel`, output, ADDRSIZE+1: registered occupancy, from 0 to 2^ADDRSIZE.
- `runderflow`, output, 1: sticky flag recording a read attempted while empty.

## Operation
- Internal register `rbin` is ADDRSIZE+1 bits.
- `rbinnext` = `rbin` + (`rinc` & ~`rempty`), computed modulo 2^(ADDRSIZE+1) with natural wrap.
- `rgraynext` = (`rbinnext` >> 1) ^ `rbinnext`.
- On every clock edge, `rbin` takes `rbinnext` and `rptr` takes `rgraynext`.
- Empty condition: `rempty` takes (`rgraynext` == `rq2_wptr`). This is a full-width compare, including the wrap MSB.
- Write binary: `wbin_s` = gray-to-binary(`rq2_wptr`). It is combinational: bit i is the XOR of `rq2_wptr` bits ADDRSIZE down to i.
- Level: `rlevel` takes (`wbin_s` − `rbinnext`) modulo 2^(ADDRSIZE+1).
- Almost-empty: `raempty` takes (next level ≤ `AEMPTY_THRESH`). It is always 1 whenever `rempty` is 1.
- Underflow: `runderflow` is set by (`rinc` & `rempty`). Once set, it clears only on `rrst`.
- A read attempted while empty is ignored: `rbin`, `rptr` and `raddr` hold their values.
- Reset values (`rrst`=1 at an `rclk` edge):
  - `rbin`=0, `rptr`=0, `raddr`=0
  - `rempty`=1, `raempty`=1
  - `rlevel`=0, `runderflow`=0
- Reset overrides `rinc` in the same cycle.
- Reset while data is present drops all words.
- The write domain must be reset coherently; that is a system-level responsibility. This block does no cross-domain reset handshake.

## Timing
- `raddr` is valid in the cycle `rinc` is sampled. RAM data for that address is the current word.
- The pointer advances on the `rclk` edge where `rinc` & ~`rempty` holds.
- `rempty` rises on the same edge that accepts the final read. No further read can be accepted in the following cycle.
- `rempty` falls one `rclk` edge after `rq2_wptr` changes. Measured from the write itself, that is pessimistically 3 or more `rclk` edges because of the external synchronizer.
- `rlevel` and `raempty` follow the same one-edge latency as `rempty`.
- A simultaneous read and `rq2_wptr` change are both reflected on the same edge; the flags are computed from `rbinnext` and the current `rq2_wptr`.
- Wrap-around: when reading past address 2^ADDRSIZE−1, `raddr` returns to 0 and the `rbin` MSB toggles. Empty detection stays correct across the wrap.
- `rptr` changes by at most one bit per edge.

## Configuration
- Macro `RPTR_EMPTY_LEVEL_EN`.
- Defined: `wbin_s`, `rlevel` and `raempty` are implemented exactly as specified above.
- Undefined: the Gray-to-binary conversion and the subtractor are not built.
  - `rlevel` is tied to 0.
  - `raempty` is a copy of `rempty` and follows it on the same edge.
  - `rempty`, `rptr`, `raddr` and `runderflow` are unchanged.

## Test plan
All scenarios use ADDRSIZE=4, AEMPTY_THRESH=2, and `RPTR_EMPTY_LEVEL_EN` defined unless stated otherwise.
- **Reset:** `rrst`=1 for one edge with random `rinc`. Expect `rptr`=0, `raddr`=0, `rempty`=1, `raempty`=1, `rlevel`=0, `runderflow`=0.
- **Drain 3 words:** `rq2_wptr`=5'b00010 (gray of 3).
  - After one edge: `rempty`=0, `rlevel`=3, `raempty`=0.
  - With `rinc`=1 for 3 cycles: `raddr` sequence is 0, 1, 2. `raempty` is 1 after the first read (level 2). `rempty`=1 on the third read's edge, and `rptr`=5'b00010.
- **Underflow:** hold `rinc`=1 while `rempty`=1. Expect `raddr` to stay 3, `rptr` to stay 5'b00010, and `runderflow`=1, remaining 1 until the next `rrst`.
- **Wrap:** step `rq2_wptr` to gray(16)=5'b11000 from an empty state at `rbin`=0, then read 16 words.
  - `raddr` runs 0..15 and then reads 0 again.
  - Final `rptr`=5'b11000, `rempty`=1, `rlevel`=0.
  - `rempty`=0 throughout while `rlevel` goes 16 → 1.
- **Reset mid-operation:** with `rlevel`=5, assert `rrst` with `rinc`=1. Expect all outputs at reset values on that edge and the pointer not advanced.
- **Macro undefined:** repeat the drain-3 scenario. Expect `rlevel`=0 throughout and `raempty` equal to `rempty` on every edge.
